// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package if_id_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_INC      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_perf_cnt.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module if_id_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall/flush; optional perf counters under IFID_PERF_CNT_EN.
module if_id_reg
    import if_id_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
`ifdef IFID_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic [31:0]      instr_o,
`ifdef IFID_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
`endif
    output logic             valid_o
);

    localparam if_id_payload_t Bubble = '{
        pc:       32'd0,
        pc_plus4: 32'd0,
        instr:    NOP_INSTR,
        valid:    1'b0
    };

    if_id_payload_t slot_q, slot_d;

    // Priority below reset: disabled core > flush > stall > load.
    always_comb begin
        slot_d = slot_q;
        if (start_i) begin
            if (flush_i) begin
                slot_d = Bubble;
            end else if (!stall_i) begin
                slot_d.pc       = pc_i;
                slot_d.pc_plus4 = pc_i + PC_INC;
                slot_d.instr    = instr_i;
                slot_d.valid    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q <= Bubble;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign pc_o       = slot_q.pc;
    assign pc_plus4_o = slot_q.pc_plus4;
    assign instr_o    = slot_q.instr;
    assign valid_o    = slot_q.valid;

`ifdef IFID_PERF_CNT_EN
    logic stall_inc, flush_inc, bubble_inc;

    assign stall_inc  = start_i & stall_i & ~flush_i;
    assign flush_inc  = start_i & flush_i;
    assign bubble_inc = start_i & ~slot_q.valid;

    if_id_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    if_id_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

    if_id_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (bubble_inc),
        .cnt_o (bubble_cnt_o)
    );
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios plus randomized traffic vs a reference model.
module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFID_PERF_CNT_EN
    localparam int unsigned CNT_W = 4;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_o, pc_plus4_o, instr_o;
    logic        valid_o;
`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, bubble_cnt_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state: what decode should see after each edge.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    longint      m_stall, m_flush, m_bubble;

    always #5 clk = ~clk;

    if_id_reg #(
        .NOP_INSTR (NOP)
`ifdef IFID_PERF_CNT_EN
        ,
        .CNT_W     (CNT_W)
`endif
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .instr_o      (instr_o),
`ifdef IFID_PERF_CNT_EN
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .bubble_cnt_o (bubble_cnt_o),
`endif
        .valid_o      (valid_o)
    );

    function automatic longint sat_inc(input longint v);
`ifdef IFID_PERF_CNT_EN
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
`else
        return v + 1;
`endif
    endfunction

    // Advance model by one edge with the inputs currently driven, then wait past the edge.
    task automatic tick();
        if (rst_i) begin
            m_pc = '0; m_pc4 = '0; m_instr = NOP; m_valid = 1'b0;
            m_stall = 0; m_flush = 0; m_bubble = 0;
        end else if (start_i) begin
            if (stall_i && !flush_i) m_stall = sat_inc(m_stall);
            if (flush_i) m_flush = sat_inc(m_flush);
            if (!m_valid) m_bubble = sat_inc(m_bubble);
            if (flush_i) begin
                m_pc = '0; m_pc4 = '0; m_instr = NOP; m_valid = 1'b0;
            end else if (!stall_i) begin
                m_pc = pc_i; m_pc4 = pc_i + 32'd4; m_instr = instr_i; m_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; stall_i = 1'b1; flush_i = 1'b0;
        pc_i = 32'hDEAD_BEE0; instr_i = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {32'd0, 32'd0, 32'h13, 1'b0}) begin
                n_fail++;
                $display("FAIL reset: got pc=%h pc4=%h instr=%h v=%b want 0/0/00000013/0",
                         pc_o, pc_plus4_o, instr_o, valid_o);
            end
        end
`ifdef IFID_PERF_CNT_EN
        n_cmp++;
        if ({stall_cnt_o, flush_cnt_o, bubble_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0",
                     stall_cnt_o, flush_cnt_o, bubble_cnt_o);
        end
`endif
        rst_i = 1'b0; stall_i = 1'b0;
    endtask

    task automatic test_load();
        start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        pc_i = 32'h100; instr_i = 32'h00A0_0093;
        tick();
        n_cmp++;
        if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {32'h100, 32'h104, 32'h00A0_0093, 1'b1}) begin
            n_fail++;
            $display("FAIL load: got pc=%h pc4=%h instr=%h v=%b want 100/104/00a00093/1",
                     pc_o, pc_plus4_o, instr_o, valid_o);
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_i = $urandom; instr_i = $urandom;
            tick();
            n_cmp++;
            if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {32'h100, 32'h104, 32'h00A0_0093, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got pc=%h pc4=%h instr=%h v=%b want 100/104/00a00093/1",
                         i, pc_o, pc_plus4_o, instr_o, valid_o);
            end
        end
`ifdef IFID_PERF_CNT_EN
        n_cmp++;
        if (stall_cnt_o !== 4'd3) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d want 3", stall_cnt_o);
        end
`endif
    endtask

    task automatic test_flush_stall();
        stall_i = 1'b1; flush_i = 1'b1;
        tick();
        n_cmp++;
        if ({pc_o, instr_o, valid_o} !== {32'd0, 32'h13, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_over_stall: got pc=%h instr=%h v=%b want 0/00000013/0",
                     pc_o, instr_o, valid_o);
        end
`ifdef IFID_PERF_CNT_EN
        n_cmp++;
        if ({flush_cnt_o, stall_cnt_o} !== {4'd1, 4'd3}) begin
            n_fail++;
            $display("FAIL flush_cnt: got flush=%0d stall=%0d want 1/3", flush_cnt_o, stall_cnt_o);
        end
`endif
        stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_wrap_and_disable();
        pc_i = 32'hFFFF_FFFC; instr_i = 32'hCAFE_0013;
        tick();
        n_cmp++;
        if ({pc_o, pc_plus4_o, valid_o} !== {32'hFFFF_FFFC, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap: got pc=%h pc4=%h v=%b want fffffffc/00000000/1",
                     pc_o, pc_plus4_o, valid_o);
        end
        start_i = 1'b0; flush_i = 1'b1; pc_i = 32'h40; instr_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {32'hFFFF_FFFC, 32'd0, 32'hCAFE_0013, 1'b1}) begin
                n_fail++;
                $display("FAIL disabled_hold[%0d]: got pc=%h pc4=%h instr=%h v=%b", i,
                         pc_o, pc_plus4_o, instr_o, valid_o);
            end
        end
`ifdef IFID_PERF_CNT_EN
        n_cmp++;
        if (longint'(flush_cnt_o) !== m_flush) begin
            n_fail++;
            $display("FAIL disabled_cnt: got flush=%0d want %0d", flush_cnt_o, m_flush);
        end
`endif
        start_i = 1'b1; flush_i = 1'b0;
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_saturate();
        stall_i = 1'b1; flush_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (stall_cnt_o !== 4'hF) begin
            n_fail++;
            $display("FAIL stall_saturate: got %h want f", stall_cnt_o);
        end
        rst_i = 1'b1;
        tick();
        n_cmp++;
        if ({stall_cnt_o, flush_cnt_o, bubble_cnt_o, valid_o} !== '0) begin
            n_fail++;
            $display("FAIL cnt_clear: got %0d/%0d/%0d v=%b want 0/0/0/0",
                     stall_cnt_o, flush_cnt_o, bubble_cnt_o, valid_o);
        end
        rst_i = 1'b0; stall_i = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst_i   = ($urandom_range(0, 39) == 0);
            start_i = ($urandom_range(0, 9) != 0);
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 5) == 0);
            pc_i    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            instr_i = $urandom;
            tick();
            n_cmp++;
            if ({pc_o, pc_plus4_o, instr_o, valid_o} !== {m_pc, m_pc4, m_instr, m_valid}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b", i,
                         pc_o, pc_plus4_o, instr_o, valid_o, m_pc, m_pc4, m_instr, m_valid);
            end
`ifdef IFID_PERF_CNT_EN
            n_cmp++;
            if ({longint'(stall_cnt_o), longint'(flush_cnt_o), longint'(bubble_cnt_o)}
                    !== {m_stall, m_flush, m_bubble}) begin
                n_fail++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         stall_cnt_o, flush_cnt_o, bubble_cnt_o, m_stall, m_flush, m_bubble);
            end
`endif
        end
        rst_i = 1'b0;
    endtask

    initial begin
        m_pc = '0; m_pc4 = '0; m_instr = NOP; m_valid = 1'b0;
        m_stall = 0; m_flush = 0; m_bubble = 0;
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_wrap_and_disable();
`ifdef IFID_PERF_CNT_EN
        test_saturate();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
